// File: rtl/uart_compute_sequencer_pkg.sv
// Shared constants for the UART compute sequencer: command bytes, cu_op codes,
// FSM state codes and the decoded-command record.
package uart_compute_sequencer_pkg;

  localparam logic [7:0] CMD_SUB   = 8'h73;  // 's'
  localparam logic [7:0] CMD_MUL   = 8'h6D;  // 'm'
  localparam logic [7:0] CMD_MULH  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_MULHU = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DIV   = 8'h64;  // 'd'
  localparam logic [7:0] CMD_DIVU  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_REM   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_REMU  = 8'h4D;  // 'M'

  localparam logic [2:0] OP_SUB   = 3'd0;
  localparam logic [2:0] OP_MUL   = 3'd1;
  localparam logic [2:0] OP_MULH  = 3'd2;
  localparam logic [2:0] OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_REM   = 3'd6;
  localparam logic [2:0] OP_REMU  = 3'd7;

  localparam logic [2:0] RX_WAIT    = 3'd0;
  localparam logic [2:0] RX_RELEASE = 3'd1;
  localparam logic [2:0] DECODE     = 3'd2;
  localparam logic [2:0] WAIT_DONE  = 3'd3;
  localparam logic [2:0] TX_RES     = 3'd4;
  localparam logic [2:0] TX_ERR     = 3'd5;

  localparam logic [7:0] ERR_BYTE = 8'h3F;

  typedef struct packed {
    logic       known;
    logic [2:0] op;
  } cmd_dec_t;

endpackage

// File: rtl/uart_compute_sequencer_decode.sv
// Combinational command-byte decoder: maps a host command byte to a cu_op code
// and flags whether the byte is a recognised command.
module uart_cmd_decode
  import uart_compute_sequencer_pkg::*;
(
  input  logic [7:0] cmd,
  output cmd_dec_t   dec
);

  always_comb begin
    dec.known = 1'b1;
    dec.op    = OP_SUB;
    case (cmd)
      CMD_SUB:   dec.op = OP_SUB;
      CMD_MUL:   dec.op = OP_MUL;
      CMD_MULH:  dec.op = OP_MULH;
      CMD_MULHU: dec.op = OP_MULHU;
      CMD_DIV:   dec.op = OP_DIV;
      CMD_DIVU:  dec.op = OP_DIVU;
      CMD_REM:   dec.op = OP_REM;
      CMD_REMU:  dec.op = OP_REMU;
      default:   dec.known = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_compute_sequencer.sv
// Sequencer: collects 9-byte command packets from the UART RX handshake, issues one
// compute-unit operation, latches the result and optionally echoes it on UART TX.
module uart_compute_sequencer
  import uart_compute_sequencer_pkg::*;
#(
  parameter int CU_TIMEOUT = 1024,
  parameter bit TX_ENABLE  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  UART_RX,
  input  logic        UART_RX_valid,
  output logic        UART_RX_ack,
  output logic [7:0]  UART_TX,
  output logic        UART_TX_valid,
  input  logic        UART_TX_ready,
  output logic        cu_start,
  output logic [2:0]  cu_op,
  output logic [31:0] cu_a,
  output logic [31:0] cu_b,
  input  logic        cu_done,
  input  logic [31:0] cu_result,
  output logic [31:0] ComputeResult,
  output logic        err,
  output logic        busy
);

  localparam int TW = (CU_TIMEOUT > 2) ? $clog2(CU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CU_TIMEOUT - 1);

  logic [2:0]    state_reg;
  logic [3:0]    count_reg;
  logic [7:0]    cmd_reg;
  logic [63:0]   opnd_reg;
  logic [TW-1:0] timer_reg;
  logic [1:0]    tx_idx_reg;
  logic          ack_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic          cu_start_reg;
  logic [2:0]    cu_op_reg;
  logic [31:0]   cu_a_reg;
  logic [31:0]   cu_b_reg;
  logic [31:0]   result_reg;
  logic          err_reg;

  cmd_dec_t      dec;
  logic [7:0]    res_bytes [4];
  logic [1:0]    tx_next_idx;

  uart_cmd_decode u_decode (
    .cmd (cmd_reg),
    .dec (dec)
  );

  // Byte 0 is the most significant byte of the latched result.
  for (genvar gi = 0; gi < 4; gi++) begin : g_res_bytes
    assign res_bytes[gi] = result_reg[31-8*gi -: 8];
  end

  assign tx_next_idx = tx_idx_reg + 2'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= RX_WAIT;
      count_reg    <= '0;
      cmd_reg      <= '0;
      opnd_reg     <= '0;
      timer_reg    <= '0;
      tx_idx_reg   <= '0;
      ack_reg      <= 1'b0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      cu_start_reg <= 1'b0;
      cu_op_reg    <= '0;
      cu_a_reg     <= '0;
      cu_b_reg     <= '0;
      result_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      cu_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      case (state_reg)
        RX_WAIT: begin
          if (UART_RX_valid) begin
            // Operand bytes shift in MSB first, so op1 ends up in the upper word.
            if (count_reg == 4'd0) cmd_reg <= UART_RX;
            else                   opnd_reg <= {opnd_reg[55:0], UART_RX};
            ack_reg   <= 1'b1;
            state_reg <= RX_RELEASE;
          end
        end
        RX_RELEASE: begin
          if (!UART_RX_valid) begin
            ack_reg <= 1'b0;
            if (count_reg == 4'd8) begin
              count_reg <= '0;
              state_reg <= DECODE;
            end else begin
              count_reg <= count_reg + 4'd1;
              state_reg <= RX_WAIT;
            end
          end
        end
        DECODE: begin
          if (dec.known) begin
            cu_op_reg    <= dec.op;
            cu_a_reg     <= opnd_reg[63:32];
            cu_b_reg     <= opnd_reg[31:0];
            cu_start_reg <= 1'b1;
            timer_reg    <= '0;
            state_reg    <= WAIT_DONE;
          end else begin
            err_reg <= 1'b1;
            if (TX_ENABLE) begin
              tx_data_reg  <= ERR_BYTE;
              tx_valid_reg <= 1'b1;
              state_reg    <= TX_ERR;
            end else begin
              state_reg <= RX_WAIT;
            end
          end
        end
        WAIT_DONE: begin
          // A completion on the final counted cycle still wins over the timeout.
          if (cu_done) begin
            result_reg <= cu_result;
            if (TX_ENABLE) begin
              tx_data_reg  <= cu_result[31:24];
              tx_idx_reg   <= '0;
              tx_valid_reg <= 1'b1;
              state_reg    <= TX_RES;
            end else begin
              state_reg <= RX_WAIT;
            end
          end else if (timer_reg == TIMEOUT_LAST) begin
            err_reg <= 1'b1;
            if (TX_ENABLE) begin
              tx_data_reg  <= ERR_BYTE;
              tx_valid_reg <= 1'b1;
              state_reg    <= TX_ERR;
            end else begin
              state_reg <= RX_WAIT;
            end
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        TX_RES: begin
          if (UART_TX_ready) begin
            if (tx_idx_reg == 2'd3) begin
              tx_valid_reg <= 1'b0;
              state_reg    <= RX_WAIT;
            end else begin
              tx_idx_reg  <= tx_next_idx;
              tx_data_reg <= res_bytes[tx_next_idx];
            end
          end
        end
        TX_ERR: begin
          if (UART_TX_ready) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= RX_WAIT;
          end
        end
        default: state_reg <= RX_WAIT;
      endcase
    end
  end

  assign UART_RX_ack   = ack_reg;
  assign UART_TX       = tx_data_reg;
  assign UART_TX_valid = tx_valid_reg;
  assign cu_start      = cu_start_reg;
  assign cu_op         = cu_op_reg;
  assign cu_a          = cu_a_reg;
  assign cu_b          = cu_b_reg;
  assign ComputeResult = result_reg;
  assign err           = err_reg;
  assign busy          = !((state_reg == RX_WAIT) && (count_reg == 4'd0));

endmodule

// File: tb/tb_uart_compute_sequencer.sv
// Randomized scoreboard bench for uart_compute_sequencer: a behavioural model predicts
// cu issues, TX bytes, err pulses and ComputeResult; monitors compare as the DUT emits.
module tb_uart_compute_sequencer;

  localparam int CU_TIMEOUT = 1024;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  UART_RX;
  logic        UART_RX_valid;
  logic        UART_RX_ack;
  logic [7:0]  UART_TX;
  logic        UART_TX_valid;
  logic        UART_TX_ready;
  logic        cu_start;
  logic [2:0]  cu_op;
  logic [31:0] cu_a, cu_b;
  logic        cu_done;
  logic [31:0] cu_result;
  logic [31:0] ComputeResult;
  logic        err;
  logic        busy;

  uart_compute_sequencer #(.CU_TIMEOUT(CU_TIMEOUT), .TX_ENABLE(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .UART_RX(UART_RX), .UART_RX_valid(UART_RX_valid), .UART_RX_ack(UART_RX_ack),
    .UART_TX(UART_TX), .UART_TX_valid(UART_TX_valid), .UART_TX_ready(UART_TX_ready),
    .cu_start(cu_start), .cu_op(cu_op), .cu_a(cu_a), .cu_b(cu_b),
    .cu_done(cu_done), .cu_result(cu_result),
    .ComputeResult(ComputeResult), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } cu_exp_t;
  cu_exp_t     cu_q[$];
  logic [7:0]  tx_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, err_cyc = 0, err_seen = 0, tx_pops = 0;
  int cu_latency = 1;
  bit cu_hang = 0, cu_pend = 0;
  logic [31:0] hold_a, hold_b, model_res;
  bit force_ready = 0, force_val = 1, ready_rand = 1;

  assign UART_TX_ready = force_ready ? force_val : ready_rand;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural view of the compute unit (RISC-V M-extension rules).
  function automatic logic [31:0] ref_calc(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      0: return a - b;
      1: begin p = ua * ub; return p[31:0]; end
      2: begin p = sa * sb; return p[63:32]; end
      3: begin p = ua * ub; return p[63:32]; end
      4: if (b == 0) return 32'hFFFF_FFFF; else begin p = sa / sb; return p[31:0]; end
      5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      6: if (b == 0) return a; else begin p = sa % sb; return p[31:0]; end
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic bit cmd_map(input logic [7:0] c, output int op);
    op = 0;
    case (c)
      8'h73: op = 0;  8'h6D: op = 1;  8'h48: op = 2;  8'h68: op = 3;
      8'h64: op = 4;  8'h44: op = 5;  8'h72: op = 6;  8'h4D: op = 7;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  initial forever begin
    @(posedge CLK); #1;
    ready_rand = ($urandom_range(0, 3) != 0);
  end

  // Compute-unit model: answers each issue after cu_latency cycles, then sends a stray done.
  initial begin
    int c_op;
    cu_done = 1'b0;
    cu_result = '0;
    forever begin
      @(negedge CLK);
      if (cu_start && !RESET && !cu_hang) begin
        c_op = int'(cu_op); hold_a = cu_a; hold_b = cu_b; cu_pend = 1;
        for (int i = 1; i < cu_latency; i++) begin
          @(posedge CLK); #1; cu_result = $urandom;
        end
        @(posedge CLK); #1; cu_done = 1'b1; cu_result = ref_calc(c_op, hold_a, hold_b);
        @(posedge CLK); #1; cu_done = 1'b0; cu_pend = 0;
        @(posedge CLK); #1; cu_done = 1'b1; cu_result = $urandom;
        @(posedge CLK); #1; cu_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents an issue or a TX byte.
  always @(negedge CLK) begin
    cu_exp_t e;
    if (!RESET) begin
      if (cu_start) begin
        start_cyc = cyc;
        if (cu_q.size() == 0) chk("cu_start_unexpected", 64'(cu_start), 64'(0));
        else begin
          e = cu_q.pop_front();
          chk("cu_op", 64'(cu_op), 64'(e.op));
          chk("cu_a", 64'(cu_a), 64'(e.a));
          chk("cu_b", 64'(cu_b), 64'(e.b));
        end
      end
      if (cu_pend) begin
        chk("busy_in_compute", 64'(busy), 64'(1));
        chk("cu_a_stable", 64'(cu_a), 64'(hold_a));
        chk("cu_b_stable", 64'(cu_b), 64'(hold_b));
      end
      if (UART_TX_valid) begin
        if (tx_q.size() == 0) begin
          if (UART_TX_ready) chk("tx_unexpected", 64'(UART_TX_valid), 64'(0));
        end else if (UART_TX_ready) begin
          chk("tx_byte", 64'(UART_TX), 64'(tx_q.pop_front()));
          tx_pops++;
        end else begin
          chk("tx_stable", 64'(UART_TX), 64'(tx_q[0]));
        end
      end
      if (err) begin
        err_seen++;
        err_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(posedge CLK); #1;
    UART_RX = b;
    UART_RX_valid = 1'b1;
    n = 0;
    while (UART_RX_ack !== 1'b1 && n < 5000) begin @(posedge CLK); #1; n++; end
    if (n >= 5000) chk("rx_ack_timeout", 64'(UART_RX_ack), 64'(1));
    UART_RX_valid = 1'b0;
    n = 0;
    while (UART_RX_ack !== 1'b0 && n < 5000) begin @(posedge CLK); #1; n++; end
    if (n >= 5000) chk("rx_release_timeout", 64'(UART_RX_ack), 64'(0));
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge CLK); #2; n++; end while (busy && n < 6000);
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic run_packet(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input int lat, input bit hang, input bit bp);
    int op, err0, p0;
    bit known;
    logic [31:0] r;
    known = cmd_map(cmd, op);
    cu_latency = lat;
    cu_hang = hang;
    err0 = err_seen;
    if (known) begin
      cu_q.push_back('{op[2:0], a, b});
      if (hang) tx_q.push_back(8'h3F);
      else begin
        r = ref_calc(op, a, b);
        model_res = r;
        for (int i = 3; i >= 0; i--) tx_q.push_back(r[8*i +: 8]);
      end
    end else begin
      tx_q.push_back(8'h3F);
    end
    if (bp) begin force_ready = 1; force_val = 1; end
    p0 = tx_pops;
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
    if (bp) begin
      int n = 0;
      while (tx_pops == p0 && n < 3000) begin @(posedge CLK); #2; n++; end
      force_val = 0;
      repeat (20) @(posedge CLK);
      #2;
      chk("bp_hold_count", 64'(tx_pops), 64'(p0 + 1));
      force_val = 1;
    end
    wait_idle();
    force_ready = 0;
    chk("compute_result", 64'(ComputeResult), 64'(model_res));
    chk("err_pulses", 64'(err_seen - err0), 64'((known && !hang) ? 0 : 1));
    chk("tx_drained", 64'(tx_q.size()), 64'(0));
    chk("cu_drained", 64'(cu_q.size()), 64'(0));
    if (known && hang) chk("timeout_cycles", 64'(err_cyc - start_cyc), 64'(CU_TIMEOUT));
    $display("[TB] pkt cmd=%02h a=%08h b=%08h lat=%0d hang=%0d -> ComputeResult=%08h",
             cmd, a, b, lat, hang, ComputeResult);
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack", 64'(UART_RX_ack), 64'(0));
    chk("rst_tx", 64'(UART_TX), 64'(0));
    chk("rst_tx_valid", 64'(UART_TX_valid), 64'(0));
    chk("rst_cu_start", 64'(cu_start), 64'(0));
    chk("rst_cu_op", 64'(cu_op), 64'(0));
    chk("rst_cu_a", 64'(cu_a), 64'(0));
    chk("rst_cu_b", 64'(cu_b), 64'(0));
    chk("rst_result", 64'(ComputeResult), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [5];
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [7:0] cmds [8];
    logic [7:0] c;
    int dummy;
    cmds = '{8'h73, 8'h6D, 8'h48, 8'h68, 8'h64, 8'h44, 8'h72, 8'h4D};
    RESET = 1'b1;
    UART_RX = '0;
    UART_RX_valid = 1'b0;
    model_res = '0;
    repeat (3) @(posedge CLK);
    #2;
    check_reset_outputs();
    RESET = 1'b0;

    run_packet(8'h73, 32'd9, 32'd5, 1, 0, 0);                  // SUB 9-5
    run_packet(8'h64, 32'd14, 32'd2, 33, 0, 0);                // DIV 14/2
    run_packet(8'h78, 32'd1, 32'd2, 1, 0, 0);                  // unknown 'x'
    run_packet(8'h6D, 32'd6, 32'd7, 3, 0, 0);                  // MUL 6*7
    run_packet(8'h72, 32'hFFFF_FFF2, 32'd3, 2, 0, 1);          // REM -14%3 with TX stall
    run_packet(8'h44, 32'h8000_0000, 32'd2, 1, 1, 0);          // DIVU, cu never completes

    // Reset after 4 bytes of a packet discards it entirely.
    send_byte(8'h6D);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    @(posedge CLK); #3;
    RESET = 1'b1;
    #1;
    check_reset_outputs();
    model_res = '0;
    repeat (2) @(posedge CLK);
    #3;
    RESET = 1'b0;
    run_packet(8'h68, 32'h8000_0000, 32'd2, 4, 0, 0);          // MULHU -> 1

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        do c = 8'($urandom); while (cmd_map(c, dummy));
      end else begin
        c = cmds[$urandom_range(0, 7)];
      end
      run_packet(c, pick_operand(), pick_operand(), int'($urandom_range(1, 40)), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required t<900000", $time);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
